// File: rtl/vec_switch_arbiter_pkg.sv
// vec_switch_arbiter_pkg: shared vector typedefs used by VecCore and the switch fabric
package vec_switch_arbiter_pkg;
    localparam int FLOAT_BITS = 32;
    typedef enum logic [1:0] {VEC_ADD, VEC_SUB, VEC_MUL, VEC_MAC} VecAluOp_t;
    typedef enum logic [1:0] {VEC_LOAD, VEC_STORE, VEC_SEND, VEC_RECV} VecMemOp_t;
    typedef enum logic {IDLE, DELIVER} VecSwitchState_t;
endpackage

// File: rtl/vec_switch_arbiter_rr.sv
// vec_rr_arbiter: round-robin pick of one requester, searching upward from rr_ptr
module vec_rr_arbiter #(
    parameter int SWITCH_CORE_SIZE = 4,
    parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
    input  logic [SWITCH_CORE_SIZE-1:0]      req,
    input  logic [SWITCH_CORE_ADDR_SIZE-1:0] rr_ptr,
    output logic [SWITCH_CORE_SIZE-1:0]      grant,
    output logic [SWITCH_CORE_ADDR_SIZE-1:0] grant_idx
);
    logic [SWITCH_CORE_ADDR_SIZE-1:0] idx;
    logic found;
    always_comb begin
        idx = '0;
        found = 1'b0;
        grant_idx = '0;
        // walk from farthest to nearest so the closest requester to rr_ptr wins
        for (int k = SWITCH_CORE_SIZE - 1; k >= 0; k--) begin
            idx = SWITCH_CORE_ADDR_SIZE'((int'(rr_ptr) + k) % SWITCH_CORE_SIZE);
            if (req[idx]) begin
                found = 1'b1;
                grant_idx = idx;
            end
        end
        grant = found ? (SWITCH_CORE_SIZE'(1) << grant_idx) : '0;
    end
endmodule

// File: rtl/vec_switch_arbiter.sv
// vec_switch_arbiter: matches sender/receiver core pairs and moves one vector per two cycles
module vec_switch_arbiter
    import vec_switch_arbiter_pkg::*;
#(
    parameter int SWITCH_WIDTH = 16,
    parameter int SWITCH_CORE_SIZE = 4,
    parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
    input  logic                                                          clock,
    input  logic                                                          reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                                   send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]        send_core_idx,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][FLOAT_BITS-1:0] send_data,
    output logic [SWITCH_CORE_SIZE-1:0]                                   send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                                   recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]        recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                                   recv_ready,
    output logic [SWITCH_WIDTH-1:0][FLOAT_BITS-1:0]                       recv_data,
    output logic                                                          busy,
    output logic [31:0]                                                   xfer_count
);
    VecSwitchState_t state, next_state;
    logic [SWITCH_CORE_SIZE-1:0] match, grant;
    logic [SWITCH_CORE_ADDR_SIZE-1:0] grant_idx, rr_ptr, src_idx, dst_idx;
    logic launch;

    // a sender is eligible only when its destination asks for it by name
    always_comb begin
        match = '0;
        for (int i = 0; i < SWITCH_CORE_SIZE; i++)
            match[i] = send_ready[i] && recv_request[send_core_idx[i]]
                && recv_core_idx[send_core_idx[i]] == SWITCH_CORE_ADDR_SIZE'(i)
                && send_core_idx[i] != SWITCH_CORE_ADDR_SIZE'(i);
    end

    vec_rr_arbiter #(
        .SWITCH_CORE_SIZE(SWITCH_CORE_SIZE),
        .SWITCH_CORE_ADDR_SIZE(SWITCH_CORE_ADDR_SIZE)
    ) u_arb (
        .req(match),
        .rr_ptr(rr_ptr),
        .grant(grant),
        .grant_idx(grant_idx)
    );

    always_comb begin
        launch = state == IDLE && |grant;
        next_state = (state == DELIVER) ? IDLE : (launch ? DELIVER : IDLE);
        busy = state == DELIVER;
        send_ok = busy ? (SWITCH_CORE_SIZE'(1) << src_idx) : '0;
        recv_ready = busy ? (SWITCH_CORE_SIZE'(1) << dst_idx) : '0;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= next_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            src_idx <= '0;
            dst_idx <= '0;
            recv_data <= '0;
            xfer_count <= '0;
        end else if (launch) begin
            recv_data <= send_data[grant_idx];
            src_idx <= grant_idx;
            dst_idx <= send_core_idx[grant_idx];
            rr_ptr <= (grant_idx == SWITCH_CORE_ADDR_SIZE'(SWITCH_CORE_SIZE - 1)) ? '0 : grant_idx + 1'b1;
            xfer_count <= xfer_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_vec_switch_arbiter.sv
// tb_vec_switch_arbiter: scoreboarded random and directed checks against a transfer-level model
module tb_vec_switch_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] send_ready, recv_request, send_ok, recv_ready;
    logic [N-1:0][1:0] send_core_idx, recv_core_idx;
    logic [N-1:0][W-1:0][31:0] send_data;
    logic [W-1:0][31:0] recv_data;
    logic busy;
    logic [31:0] xfer_count;

    typedef struct {
        int src;
        int dst;
        logic [W*32-1:0] data;
        logic [31:0] cnt;
    } exp_t;
    exp_t exp_q[$];
    exp_t me;
    int checks = 0, failures = 0;
    int m_rr, mi, mj;
    bit m_phase;
    logic [31:0] m_cnt;
    logic [31:0] cnt_off = 32'd0;
    int acks = 0, ticks = 0, a0, t0;
    bit busy_seen;
    int ack_src[$];
    int ack_tick[$];

    always #5 clock = ~clock;

    vec_switch_arbiter #(.SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N), .SWITCH_CORE_ADDR_SIZE(2)) dut (
        .clock(clock), .reset(reset),
        .send_ready(send_ready), .send_core_idx(send_core_idx), .send_data(send_data),
        .send_ok(send_ok),
        .recv_request(recv_request), .recv_core_idx(recv_core_idx),
        .recv_ready(recv_ready), .recv_data(recv_data),
        .busy(busy), .xfer_count(xfer_count)
    );

    task automatic check(string name, logic [W*32-1:0] act, logic [W*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fbits(int k);
        int e = 0;
        if (k == 0) return 32'd0;
        while ((1 << (e + 1)) <= k) e++;
        return {1'b0, 8'(127 + e), 23'(k << (23 - e))};
    endfunction

    // transfer-level model: one grant per IDLE visit, round-robin over senders
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rr = 0;
            m_phase = 0;
            m_cnt = 0;
            exp_q.delete();
        end else if (m_phase) begin
            m_phase = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                mi = (m_rr + k) % N;
                mj = int'(send_core_idx[mi]);
                if (send_ready[mi] && recv_request[mj] && int'(recv_core_idx[mj]) == mi && mi != mj) begin
                    m_cnt = m_cnt + 1;
                    exp_q.push_back('{mi, mj, send_data[mi], m_cnt + cnt_off});
                    m_rr = (mi + 1) % N;
                    m_phase = 1;
                    break;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && (send_ok != 0 || recv_ready != 0 || exp_q.size() != 0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", {send_ok, recv_ready}, 0);
            end else begin
                me = exp_q.pop_front();
                check("send_ok", send_ok, 1 << me.src);
                check("recv_ready", recv_ready, 1 << me.dst);
                check("recv_data", recv_data, me.data);
                check("xfer_count", xfer_count, me.cnt);
                check("busy", busy, 1);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        ticks++;
        if (busy) busy_seen = 1;
        for (int i = 0; i < N; i++) begin
            if (send_ok[i]) begin
                send_ready[i] = 1'b0;
                acks++;
                ack_src.push_back(i);
                ack_tick.push_back(ticks);
            end
            if (recv_ready[i]) recv_request[i] = 1'b0;
        end
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic set_send(int i, int j, bit ramp);
        send_ready[i] = 1'b1;
        send_core_idx[i] = 2'(j);
        for (int k = 0; k < W; k++) send_data[i][k] = ramp ? fbits(k) : 32'($urandom);
    endtask

    task automatic set_recv(int j, int i);
        recv_request[j] = 1'b1;
        recv_core_idx[j] = 2'(i);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        send_ready = '0;
        recv_request = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        send_ready = '0;
        recv_request = '0;
        send_core_idx = '0;
        recv_core_idx = '0;
        send_data = '0;
        repeat (2) @(negedge clock);
        check("rst_send_ok", send_ok, 0);
        check("rst_recv_ready", recv_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_xfer_count", xfer_count, 0);
        check("rst_recv_data", recv_data, 0);
        set_send(0, 2, 1);
        set_recv(2, 0);
        tick();
        check("no_grant_in_reset", busy, 0);
        reset = 1'b0;
        a0 = acks;
        tick();
        check("single_pair_ack", acks - a0, 1);
        check("single_pair_count", xfer_count, 1);
        run(2);

        a0 = acks;
        set_send(1, 3, 0);
        set_recv(3, 2);
        run(20);
        check("mismatch_no_ack", acks - a0, 0);
        set_recv(3, 1);
        run(3);
        check("mismatch_resolved", acks - a0, 1);

        pulse_reset();
        t0 = ticks;
        ack_src.delete();
        ack_tick.delete();
        set_send(0, 1, 0); set_recv(1, 0);
        set_send(2, 3, 0); set_recv(3, 2);
        set_send(3, 0, 0); set_recv(0, 3);
        run(7);
        check("contention_count", ack_src.size(), 3);
        for (int k = 0; k < 3 && k < ack_src.size(); k++) begin
            check("contention_order", ack_src[k], (k == 0) ? 0 : k + 1);
            check("contention_cycle", ack_tick[k] - t0, 2 * k + 1);
        end
        check("contention_rr_ptr", dut.rr_ptr, 0);

        a0 = acks;
        busy_seen = 0;
        set_send(1, 1, 0);
        set_recv(1, 1);
        run(10);
        check("self_no_ack", acks - a0, 0);
        check("self_busy", busy_seen, 0);

        pulse_reset();
        set_send(2, 1, 0);
        set_recv(1, 2);
        tick();
        check("abort_in_deliver", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_send_ok", send_ok, 0);
        check("abort_recv_ready", recv_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_recv_data", recv_data, 0);
        check("abort_xfer_count", xfer_count, 0);
        send_ready = '0;
        recv_request = '0;
        tick();
        reset = 1'b0;

        a0 = acks;
        repeat (600) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!send_ready[i] && $urandom_range(3) == 0) set_send(i, $urandom_range(3), 0);
                if (!recv_request[i] && $urandom_range(3) == 0) set_recv(i, $urandom_range(3));
                if ($urandom_range(15) == 0) send_ready[i] = 1'b0;
                if ($urandom_range(15) == 0) recv_request[i] = 1'b0;
            end
        end
        send_ready = '0;
        recv_request = '0;
        run(4);
        check("random_activity", acks - a0 > 20, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        set_send(2, 0, 0);
        set_recv(0, 2);
        run(3);
        check("rr_ptr_at_3", dut.rr_ptr, 3);
        force dut.xfer_count = 32'hFFFF_FFFF;
        #1 release dut.xfer_count;
        cnt_off = 32'hFFFF_FFFF - m_cnt;
        ack_src.delete();
        set_send(3, 1, 0); set_recv(1, 3);
        set_send(0, 2, 0); set_recv(2, 0);
        run(5);
        check("wrap_count_acks", ack_src.size(), 2);
        if (ack_src.size() == 2) begin
            check("wrap_first_sender", ack_src[0], 3);
            check("wrap_second_sender", ack_src[1], 0);
        end
        check("wrap_xfer_count", xfer_count, 1);
        check("wrap_rr_ptr", dut.rr_ptr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
